// File: rtl/jam_pkg.sv
// jam_pkg: shared widths and host state encoding for the JAM cost host
package jam_pkg;
  localparam int COST_W = 7;
  localparam int MC_W = 4;
  localparam int MIN_W = 10;
  localparam int N_ENTRIES = 64;
  localparam int IDX_W = 6;
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE,
    S_TMO
  } jam_host_state_t;
endpackage

// File: rtl/jam_cost_mem.sv
// jam_cost_mem: 64-entry cost matrix, one write port and one registered read port
module jam_cost_mem
  import jam_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [COST_W-1:0] wr_data_i,
  input  logic              en_i,
  input  logic [IDX_W-1:0]  rd_addr_i,
  output logic [COST_W-1:0] rd_data_o
);
  logic [COST_W-1:0] mem_q [N_ENTRIES];
  logic [COST_W-1:0] rd_q;
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[wr_idx_i] <= wr_data_i;
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) rd_q <= '0;
    else if (en_i) rd_q <= mem_q[rd_addr_i];
  end
  assign rd_data_o = rd_q;
endmodule

// File: rtl/jam_cost_host.sv
// jam_cost_host: loads the cost matrix, releases the JAM core, serves Cost and captures its result
module jam_cost_host
  import jam_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 65535,
  parameter int          CYC_W = 20
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [COST_W-1:0] ld_data,
  output logic              jam_rst_n,
  input  logic [2:0]        W,
  input  logic [2:0]        J,
  output logic [COST_W-1:0] Cost,
  input  logic [MC_W-1:0]   MatchCount,
  input  logic [MIN_W-1:0]  MinCost,
  input  logic              Valid,
  output logic [MC_W-1:0]   res_match,
  output logic [MIN_W-1:0]  res_min,
  output logic [CYC_W-1:0]  res_cycles,
  output logic              done,
  output logic              timeout,
  output logic              busy
);
  jam_host_state_t   state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CYC_W-1:0]  cnt_q, cnt_d;
  logic              cap;
  logic [MC_W-1:0]   res_match_q;
  logic [MIN_W-1:0]  res_min_q;
  logic [CYC_W-1:0]  res_cycles_q;
  logic              ld_ready_q, run_q, done_q, timeout_q, busy_q;
  logic [COST_W-1:0] rd_data;

  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    cnt_d = run_q ? cnt_q + CYC_W'(1) : '0;
    cap = 1'b0;
    case (state_q)
      S_IDLE, S_DONE, S_TMO: begin
        if (start) begin
          state_d = S_LOAD;
          idx_d = '0;
        end
      end
      S_LOAD: begin
        if (ld_valid) begin
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(N_ENTRIES - 1)) state_d = S_RUN;
        end
      end
      S_RUN: begin
        // a result arriving on the timeout cycle still counts as success
        if (Valid) begin
          state_d = S_DONE;
          cap = 1'b1;
        end else if (cnt_q == CYC_W'(TIMEOUT_CYC)) state_d = S_TMO;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      idx_q <= '0;
      cnt_q <= '0;
      res_match_q <= '0;
      res_min_q <= '0;
      res_cycles_q <= '0;
      ld_ready_q <= 1'b0;
      run_q <= 1'b0;
      done_q <= 1'b0;
      timeout_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      if (cap) begin
        res_match_q <= MatchCount;
        res_min_q <= MinCost;
        res_cycles_q <= cnt_q;
      end
      ld_ready_q <= state_d == S_LOAD;
      run_q <= state_d == S_RUN;
      done_q <= state_d == S_DONE;
      timeout_q <= state_d == S_TMO;
      busy_q <= state_d == S_LOAD || state_d == S_RUN;
    end
  end

  jam_cost_mem u_mem (
    .clk_i     (CLK),
    .rst_n_i   (RST),
    .we_i      (ld_ready_q && ld_valid),
    .wr_idx_i  (idx_q),
    .wr_data_i (ld_data),
    .en_i      (run_q),
    .rd_addr_i ({W, J}),
    .rd_data_o (rd_data)
  );

  assign Cost = run_q ? rd_data : '0;
  assign ld_ready = ld_ready_q;
  assign jam_rst_n = run_q;
  assign res_match = res_match_q;
  assign res_min = res_min_q;
  assign res_cycles = res_cycles_q;
  assign done = done_q;
  assign timeout = timeout_q;
  assign busy = busy_q;
endmodule
